// File: rtl/lvds_panel_timing_gen_if.sv
// ============================================================================
// Module   : lvds_panel_timing_gen_if
// Brief    : Control, pixel-source and serialiser-side bundle for the panel
//            timing generator.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface lvds_panel_timing_gen_if #(
  parameter int CHANNELS = 1
) ();
  logic                     en;
  logic [2:0]               mode;
  logic [17:0]              fg_color;
  logic [18*CHANNELS-1:0]   pix_in;
  logic                     pix_req;
  logic [21*CHANNELS-1:0]   lvds_data;
  logic                     frame_start;
  logic [15:0]              frame_count;

  modport master (
    output en, mode, fg_color, pix_in,
    input  pix_req, lvds_data, frame_start, frame_count
  );

  modport slave (
    input  en, mode, fg_color, pix_in,
    output pix_req, lvds_data, frame_start, frame_count
  );
endinterface

`default_nettype wire

// File: rtl/lvds_panel_timing_gen.sv
// ============================================================================
// Module   : lvds_panel_timing_gen
// Brief    : Raster timing, test-pattern and 7:1 LVDS word packer for one or
//            two pixels per clock.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lvds_panel_timing_gen #(
  parameter int H_ACTIVE = 1366,
  parameter int H_FRONT  = 48,
  parameter int H_SYNC   = 32,
  parameter int H_BACK   = 94,
  parameter int V_ACTIVE = 768,
  parameter int V_FRONT  = 3,
  parameter int V_SYNC   = 6,
  parameter int V_BACK   = 3,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CHANNELS = 1
) (
  input logic                    clk,
  input logic                    rst,
  lvds_panel_timing_gen_if.slave bus
);

  localparam int c_h_total  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int c_v_total  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int c_width_px = H_ACTIVE * CHANNELS;
  localparam int c_bw       = ((c_width_px / 8) > 0) ? (c_width_px / 8) : 1;

  localparam logic [11:0] c_h_last  = 12'(c_h_total - 1);
  localparam logic [11:0] c_v_last  = 12'(c_v_total - 1);
  localparam logic [11:0] c_h_act   = 12'(H_ACTIVE);
  localparam logic [11:0] c_v_act   = 12'(V_ACTIVE);
  localparam logic [11:0] c_hs_beg  = 12'(H_ACTIVE + H_FRONT);
  localparam logic [11:0] c_hs_end  = 12'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [11:0] c_vs_beg  = 12'(V_ACTIVE + V_FRONT);
  localparam logic [11:0] c_vs_end  = 12'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic [11:0] c_y_last  = 12'(V_ACTIVE - 1);
  localparam logic [15:0] c_x_last  = 16'(c_width_px - 1);
  localparam logic [15:0] c_bw16    = 16'(c_bw);
  localparam logic [15:0] c_chn     = 16'(CHANNELS);
  localparam logic [17:0] c_white   = 18'h3FFFF;

  localparam logic [2:0] c_mode_ext    = 3'd0;
  localparam logic [2:0] c_mode_solid  = 3'd1;
  localparam logic [2:0] c_mode_bars   = 3'd2;
  localparam logic [2:0] c_mode_ramp   = 3'd3;
  localparam logic [2:0] c_mode_check  = 3'd4;
  localparam logic [2:0] c_mode_border = 3'd5;

  logic [11:0]              r_hcnt;
  logic [11:0]              r_vcnt;
  logic [2:0]               r_mode;
  logic [17:0]              r_fg;
  logic [21*CHANNELS-1:0]   r_lvds;
  logic                     r_fs;
  logic [15:0]              r_fc;

  logic                     w_origin;
  logic                     w_h_last;
  logic                     w_v_last;
  logic                     w_frame_end;
  logic                     w_latch;
  logic [2:0]               w_mode;
  logic [17:0]              w_fg;
  logic                     w_active;
  logic                     w_hs_on;
  logic                     w_vs_on;
  logic                     w_hs;
  logic                     w_vs;
  logic                     w_ext;
  logic [21*CHANNELS-1:0]   w_word;
  logic [21*CHANNELS-1:0]   w_rst_word;

  // Pattern colour for one pixel; outside-active blanking is applied by the caller.
  function automatic logic [17:0] pattern(
    input logic [2:0]  mode,
    input logic [15:0] x,
    input logic [11:0] y,
    input logic [17:0] fg,
    input logic [17:0] ext
  );
    logic [15:0] bar;
    logic [2:0]  idx;
    logic        on_border;
    logic [17:0] res;
    bar       = x / c_bw16;
    idx       = (bar > 16'd7) ? 3'd7 : bar[2:0];
    on_border = (x == 16'd0) || (x == c_x_last) || (y == 12'd0) || (y == c_y_last);
    case (mode)
      c_mode_solid:  res = fg;
      // Bar order white..black maps R/G/B to inverted index bits 1/2/0.
      c_mode_bars:   res = {{6{~idx[1]}}, {6{~idx[2]}}, {6{~idx[0]}}};
      c_mode_ramp:   res = {x[5:0], x[5:0], x[5:0]};
      c_mode_check:  res = (x[5] ^ y[5]) ? c_white : 18'd0;
      c_mode_border: res = on_border ? c_white : 18'd0;
      default:       res = ext;
    endcase
    return res;
  endfunction

  function automatic logic [20:0] pack(
    input logic [17:0] p,
    input logic        hs,
    input logic        vs,
    input logic        de
  );
    logic [5:0] r;
    logic [5:0] g;
    logic [5:0] b;
    r = p[17:12];
    g = p[11:6];
    b = p[5:0];
    return {b[2], b[3], b[4], b[5], hs, vs, de,
            g[1], g[2], g[3], g[4], g[5], b[0], b[1],
            r[0], r[1], r[2], r[3], r[4], r[5], g[0]};
  endfunction

  assign w_origin    = (r_hcnt == 12'd0) && (r_vcnt == 12'd0);
  assign w_h_last    = (r_hcnt == c_h_last);
  assign w_v_last    = (r_vcnt == c_v_last);
  assign w_frame_end = w_h_last && w_v_last;
  assign w_latch     = bus.en && w_origin;

  // The first pixel of a frame already uses the newly sampled mode/colour.
  assign w_mode = w_latch ? bus.mode     : r_mode;
  assign w_fg   = w_latch ? bus.fg_color : r_fg;

  assign w_active = bus.en && (r_hcnt < c_h_act) && (r_vcnt < c_v_act);
  assign w_hs_on  = bus.en && (r_hcnt >= c_hs_beg) && (r_hcnt < c_hs_end);
  assign w_vs_on  = bus.en && (r_vcnt >= c_vs_beg) && (r_vcnt < c_vs_end);
  assign w_hs     = w_hs_on ? HS_POL : ~HS_POL;
  assign w_vs     = w_vs_on ? VS_POL : ~VS_POL;
  assign w_ext    = (w_mode == c_mode_ext) || (w_mode[2] && w_mode[1]);

  assign bus.pix_req     = !rst && w_active && w_ext;
  assign bus.lvds_data   = r_lvds;
  assign bus.frame_start = r_fs;
  assign bus.frame_count = r_fc;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    localparam logic [15:0] c_off = 16'(c);
    logic [15:0] w_x;
    logic [17:0] w_rgb;

    assign w_x   = ({4'd0, r_hcnt} * c_chn) + c_off;
    assign w_rgb = w_active ? pattern(w_mode, w_x, r_vcnt, w_fg, bus.pix_in[18*c +: 18])
                            : 18'd0;
    assign w_word[21*c +: 21]     = pack(w_rgb, w_hs, w_vs, w_active);
    assign w_rst_word[21*c +: 21] = pack(18'd0, ~HS_POL, ~VS_POL, 1'b0);
  end

  always_ff @(posedge clk) begin
    if (rst || !bus.en) begin
      r_hcnt <= 12'd0;
      r_vcnt <= 12'd0;
    end else if (w_h_last) begin
      r_hcnt <= 12'd0;
      r_vcnt <= w_v_last ? 12'd0 : r_vcnt + 12'd1;
    end else begin
      r_hcnt <= r_hcnt + 12'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode <= c_mode_bars;
      r_fg   <= 18'd0;
    end else if (w_latch) begin
      r_mode <= bus.mode;
      r_fg   <= bus.fg_color;
    end
  end

  // A wrap is counted even when en drops on the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lvds <= w_rst_word;
      r_fs   <= 1'b0;
      r_fc   <= 16'd0;
    end else begin
      r_lvds <= w_word;
      r_fs   <= w_latch;
      if (w_frame_end) begin
        r_fc <= r_fc + 16'd1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_lvds_panel_timing_gen.sv
// ============================================================================
// Module   : tb_lvds_panel_timing_gen
// Brief    : Scoreboarded bench for single- and dual-channel panel generators.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lvds_panel_timing_gen;

  localparam int HA = 8, HF = 2, HSW = 2, HB = 2;
  localparam int VA = 4, VF = 1, VSW = 1, VB = 1;
  localparam int HT = HA + HF + HSW + HB;
  localparam int VT = VA + VF + VSW + VB;
  localparam logic [20:0] RST_WORD = 21'h018000;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [2:0]  mode;
  logic [17:0] fg;
  logic [17:0] pix0;
  logic [17:0] pix1;

  always #5 clk = ~clk;

  lvds_panel_timing_gen_if #(.CHANNELS(1)) if1 ();
  lvds_panel_timing_gen_if #(.CHANNELS(2)) if2 ();

  assign if1.en = en;  assign if1.mode = mode;  assign if1.fg_color = fg;  assign if1.pix_in = pix0;
  assign if2.en = en;  assign if2.mode = mode;  assign if2.fg_color = fg;  assign if2.pix_in = {pix1, pix0};

  lvds_panel_timing_gen #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB),
    .HS_POL(1'b0), .VS_POL(1'b0), .CHANNELS(1)
  ) d1 (.clk(clk), .rst(rst), .bus(if1));

  lvds_panel_timing_gen #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB),
    .HS_POL(1'b0), .VS_POL(1'b0), .CHANNELS(2)
  ) d2 (.clk(clk), .rst(rst), .bus(if2));

  typedef struct {
    logic [20:0] w1;
    logic [41:0] w2;
    logic        fs;
    logic [15:0] fc;
  } exp_t;

  exp_t sb[$];
  int n_vec = 0;
  int n_bad = 0;

  int          m_h, m_v, m_mode;
  logic [17:0] m_fg;
  logic [15:0] m_fc;

  logic [20:0] o_w1;
  logic [41:0] o_w2;
  logic        o_fs;
  logic [15:0] o_fc;
  logic        o_req1, o_req2;

  function automatic logic [17:0] m_pixel(int md, int x, int y, int wpx,
                                          logic [17:0] fgc, logic [17:0] ext);
    int          idx;
    logic [5:0]  r6;
    logic [17:0] res;
    case (md)
      1: res = fgc;
      2: begin
        idx = x / (wpx / 8);
        if (idx > 7) idx = 7;
        case (idx)
          0: res = 18'h3FFFF;  1: res = 18'h3FFC0;  2: res = 18'h00FFF;  3: res = 18'h00FC0;
          4: res = 18'h3F03F;  5: res = 18'h3F000;  6: res = 18'h0003F;  default: res = 18'h0;
        endcase
      end
      3: begin r6 = 6'(x); res = {r6, r6, r6}; end
      4: res = ((((x >> 5) ^ (y >> 5)) & 1) != 0) ? 18'h3FFFF : 18'h0;
      5: res = (x == 0 || x == wpx - 1 || y == 0 || y == VA - 1) ? 18'h3FFFF : 18'h0;
      default: res = ext;
    endcase
    return res;
  endfunction

  function automatic logic [20:0] m_pack(logic [17:0] p, logic hs, logic vs, logic de);
    logic [5:0] r, g, b;
    r = p[17:12]; g = p[11:6]; b = p[5:0];
    return {b[2], b[3], b[4], b[5], hs, vs, de, g[1], g[2], g[3], g[4], g[5], b[0], b[1],
            r[0], r[1], r[2], r[3], r[4], r[5], g[0]};
  endfunction

  function automatic logic [17:0] dec_rgb(logic [20:0] w);
    return {w[1], w[2], w[3], w[4], w[5], w[6],
            w[9], w[10], w[11], w[12], w[13], w[0],
            w[17], w[18], w[19], w[20], w[7], w[8]};
  endfunction

  // One clock: model predicts, scoreboard holds the prediction until the edge.
  task automatic cycle();
    exp_t        e;
    logic        act, hsv, vsv, req, org;
    logic [17:0] p;
    #1;
    if (rst) begin
      e.w1 = RST_WORD; e.w2 = {RST_WORD, RST_WORD}; e.fs = 1'b0; e.fc = 16'd0; req = 1'b0;
      m_h = 0; m_v = 0; m_mode = 2; m_fg = 18'h0; m_fc = 16'd0;
    end else begin
      org = (m_h == 0) && (m_v == 0);
      if (en && org) begin m_mode = int'(mode); m_fg = fg; end
      act = en && (m_h < HA) && (m_v < VA);
      hsv = !(en && m_h >= HA + HF && m_h < HA + HF + HSW);
      vsv = !(en && m_v >= VA + VF && m_v < VA + VF + VSW);
      req = act && (m_mode == 0 || m_mode >= 6);
      p = act ? m_pixel(m_mode, m_h, m_v, HA, m_fg, pix0) : 18'h0;
      e.w1 = m_pack(p, hsv, vsv, act);
      for (int c = 0; c < 2; c++) begin
        p = act ? m_pixel(m_mode, m_h * 2 + c, m_v, HA * 2, m_fg, (c == 1) ? pix1 : pix0) : 18'h0;
        e.w2[21*c +: 21] = m_pack(p, hsv, vsv, act);
      end
      e.fs = en && org;
      if (m_h == HT - 1 && m_v == VT - 1) m_fc = m_fc + 16'd1;
      e.fc = m_fc;
      if (!en) begin m_h = 0; m_v = 0; end
      else if (m_h == HT - 1) begin m_h = 0; m_v = (m_v == VT - 1) ? 0 : m_v + 1; end
      else m_h = m_h + 1;
    end
    o_req1 = if1.pix_req;
    o_req2 = if2.pix_req;
    n_vec++;
    if (o_req1 !== req || o_req2 !== req) begin
      n_bad++; $display("FAIL pix_req: got %b/%b want %b at t=%0t", o_req1, o_req2, req, $time);
    end
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    e = sb.pop_front();
    o_w1 = if1.lvds_data; o_w2 = if2.lvds_data; o_fs = if1.frame_start; o_fc = if1.frame_count;
    n_vec++;
    if (o_w1 !== e.w1) begin
      n_bad++; $display("FAIL word_ch1: got %h want %h at t=%0t", o_w1, e.w1, $time);
    end
    n_vec++;
    if (o_w2 !== e.w2) begin
      n_bad++; $display("FAIL word_ch2: got %h want %h at t=%0t", o_w2, e.w2, $time);
    end
    n_vec++;
    if (o_fs !== e.fs || if2.frame_start !== e.fs) begin
      n_bad++; $display("FAIL frame_start: got %b/%b want %b at t=%0t", o_fs, if2.frame_start, e.fs, $time);
    end
    n_vec++;
    if (o_fc !== e.fc || if2.frame_count !== e.fc) begin
      n_bad++; $display("FAIL frame_count: got %0d/%0d want %0d at t=%0t", o_fc, if2.frame_count, e.fc, $time);
    end
  endtask

  task automatic wait_fs();
    for (int k = 0; k < 200; k++) begin
      cycle();
      if (o_fs) break;
    end
    n_vec++;
    if (o_fs !== 1'b1) begin n_bad++; $display("FAIL wait_fs: got %b want 1 (timeout)", o_fs); end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; mode = 3'd1; fg = 18'h2A5C3; pix0 = 18'h0; pix1 = 18'h0;
    repeat (3) cycle();
    n_vec++;
    if (o_w1 !== RST_WORD || o_w2 !== {RST_WORD, RST_WORD}) begin
      n_bad++; $display("FAIL reset_word: got %h/%h want %h", o_w1, o_w2, RST_WORD);
    end
    n_vec++;
    if (o_fs !== 1'b0 || o_fc !== 16'd0 || o_req1 !== 1'b0) begin
      n_bad++; $display("FAIL reset_ctrl: got fs=%b fc=%0d req=%b want 0/0/0", o_fs, o_fc, o_req1);
    end
  endtask

  task automatic test_timing();
    int de_bad = 0, hs_bad = 0, vs_bad = 0, fs_bad = 0, de_cnt = 0;
    rst = 1'b0;
    for (int k = 0; k < 2 * HT * VT; k++) begin
      cycle();
      if (o_w1[14] !== ((k % HT) < HA && ((k % (HT * VT)) / HT) < VA)) de_bad++;
      if (o_w1[16] !== !((k % HT) == 10 || (k % HT) == 11)) hs_bad++;
      if (o_w1[15] !== !(((k % (HT * VT)) / HT) == 5)) vs_bad++;
      if (o_fs !== ((k % (HT * VT)) == 0)) fs_bad++;
      if (k < HT * VT && o_w1[14] === 1'b1) de_cnt++;
    end
    n_vec++;
    if (de_bad != 0 || de_cnt != 32) begin
      n_bad++; $display("FAIL de_timing: got %0d bad, %0d high want 0 bad, 32 high", de_bad, de_cnt);
    end
    n_vec++;
    if (hs_bad != 0) begin n_bad++; $display("FAIL hs_timing: got %0d bad want 0", hs_bad); end
    n_vec++;
    if (vs_bad != 0) begin n_bad++; $display("FAIL vs_timing: got %0d bad want 0", vs_bad); end
    n_vec++;
    if (fs_bad != 0) begin n_bad++; $display("FAIL fs_period: got %0d bad want 0", fs_bad); end
    n_vec++;
    if (o_fc !== 16'd2) begin n_bad++; $display("FAIL fc_two_frames: got %0d want 2", o_fc); end
  endtask

  task automatic test_bars();
    logic [17:0] bars [8];
    bars[0] = 18'h3FFFF; bars[1] = 18'h3FFC0; bars[2] = 18'h00FFF; bars[3] = 18'h00FC0;
    bars[4] = 18'h3F03F; bars[5] = 18'h3F000; bars[6] = 18'h0003F; bars[7] = 18'h00000;
    mode = 3'd2;
    wait_fs();
    for (int h = 0; h < HA; h++) begin
      if (h != 0) cycle();
      n_vec++;
      if (dec_rgb(o_w2[20:0]) !== bars[h] || dec_rgb(o_w1) !== bars[h]) begin
        n_bad++; $display("FAIL bar_%0d: got %h/%h want %h", h, dec_rgb(o_w2[20:0]), dec_rgb(o_w1), bars[h]);
      end
      n_vec++;
      if (o_w2[16:14] !== 3'b111 || o_w2[37:35] !== 3'b111) begin
        n_bad++; $display("FAIL bar_sync_%0d: got %b/%b want 111", h, o_w2[16:14], o_w2[37:35]);
      end
    end
  endtask

  task automatic test_external();
    int req_cnt, red_bad = 0;
    mode = 3'd0; pix0 = 18'h3F000; pix1 = 18'h3F000;
    wait_fs();
    req_cnt = int'(o_req1);
    for (int k = 0; k < HT * VT; k++) begin
      if (k != 0) begin cycle(); req_cnt += int'(o_req1); end
      if (o_w1[14] && dec_rgb(o_w1) !== 18'h3F000) red_bad++;
      if (o_w2[14] && (dec_rgb(o_w2[20:0]) !== 18'h3F000 || dec_rgb(o_w2[41:21]) !== 18'h3F000)) red_bad++;
    end
    n_vec++;
    if (req_cnt != 32) begin n_bad++; $display("FAIL pix_req_count: got %0d want 32", req_cnt); end
    n_vec++;
    if (red_bad != 0) begin n_bad++; $display("FAIL ext_red: got %0d bad words want 0", red_bad); end
    for (int k = 0; k < HT * VT; k++) begin
      pix0 = 18'($urandom); pix1 = 18'($urandom);
      cycle();
    end
  endtask

  task automatic test_mode_switch();
    int n, fg_bad = 0;
    mode = 3'd1; fg = 18'h15A5A;
    wait_fs();
    repeat (30) cycle();
    mode = 3'd4; fg = 18'h0F0F0;
    n = 0;
    for (int k = 0; k < 200; k++) begin
      cycle(); n++;
      if (o_fs) break;
      if (o_w1[14] && dec_rgb(o_w1) !== 18'h15A5A) fg_bad++;
      if (o_w2[14] && (dec_rgb(o_w2[20:0]) !== 18'h15A5A || dec_rgb(o_w2[41:21]) !== 18'h15A5A)) fg_bad++;
    end
    n_vec++;
    if (fg_bad != 0) begin n_bad++; $display("FAIL no_tear: got %0d bad words want 0", fg_bad); end
    n_vec++;
    if (n != 68 || o_fs !== 1'b1) begin n_bad++; $display("FAIL switch_fs: got %0d cycles want 68", n); end
    n_vec++;
    if (o_w1[14] !== 1'b1 || dec_rgb(o_w1) !== 18'h0) begin
      n_bad++; $display("FAIL checker_start: got de=%b rgb=%h want 1/00000", o_w1[14], dec_rgb(o_w1));
    end
  endtask

  task automatic test_patterns();
    int mds [3] = '{3, 5, 6};
    for (int i = 0; i < 3; i++) begin
      mode = 3'(mds[i]); pix0 = 18'($urandom); pix1 = 18'($urandom);
      wait_fs();
      if (mds[i] == 3) begin
        n_vec++;
        if (dec_rgb(o_w2[41:21]) !== 18'h01041) begin
          n_bad++; $display("FAIL ramp_x1: got %h want 01041", dec_rgb(o_w2[41:21]));
        end
      end else if (mds[i] == 5) begin
        n_vec++;
        if (dec_rgb(o_w1) !== 18'h3FFFF) begin
          n_bad++; $display("FAIL border_origin: got %h want 3ffff", dec_rgb(o_w1));
        end
      end
      for (int k = 1; k < HT * VT; k++) begin
        pix0 = 18'($urandom); pix1 = 18'($urandom);
        cycle();
      end
    end
  endtask

  task automatic test_reset_midline();
    mode = 3'd1; fg = 18'h0ABCD;
    for (int k = 0; k < 200 && !(m_h == 5 && m_v == 2); k++) cycle();
    rst = 1'b1;
    cycle();
    n_vec++;
    if (o_w1 !== RST_WORD || o_fc !== 16'd0 || o_fs !== 1'b0) begin
      n_bad++; $display("FAIL midline_reset: got %h fc=%0d fs=%b want %h/0/0", o_w1, o_fc, o_fs, RST_WORD);
    end
    rst = 1'b0;
    cycle();
    n_vec++;
    if (o_fs !== 1'b1 || o_w1[14] !== 1'b1) begin
      n_bad++; $display("FAIL midline_restart: got fs=%b de=%b want 1/1", o_fs, o_w1[14]);
    end
  endtask

  task automatic test_en_drop();
    int bad = 0;
    repeat (20) cycle();
    en = 1'b0;
    repeat (20) begin
      cycle();
      if (o_w1[16:14] !== 3'b110 || o_w2[16:14] !== 3'b110 || o_w2[37:35] !== 3'b110) bad++;
      if (o_req1 !== 1'b0 || o_req2 !== 1'b0 || o_fs !== 1'b0) bad++;
    end
    n_vec++;
    if (bad != 0) begin n_bad++; $display("FAIL en_low_idle: got %0d bad cycles want 0", bad); end
    en = 1'b1;
    cycle();
    n_vec++;
    if (o_fs !== 1'b1) begin n_bad++; $display("FAIL en_resume_fs: got %b want 1", o_fs); end
  endtask

  task automatic test_en_wrap();
    logic [15:0] fc_before;
    for (int k = 0; k < 200 && !(m_h == HT - 1 && m_v == VT - 1); k++) cycle();
    fc_before = m_fc;
    en = 1'b0;
    cycle();
    n_vec++;
    if (o_fc !== fc_before + 16'd1) begin
      n_bad++; $display("FAIL wrap_en_fall: got %0d want %0d", o_fc, fc_before + 16'd1);
    end
    cycle();
    n_vec++;
    if (o_fc !== fc_before + 16'd1 || o_w1[14] !== 1'b0) begin
      n_bad++; $display("FAIL wrap_hold: got fc=%0d de=%b want %0d/0", o_fc, o_w1[14], fc_before + 16'd1);
    end
    en = 1'b1;
    cycle();
    n_vec++;
    if (o_fs !== 1'b1) begin n_bad++; $display("FAIL wrap_resume: got %b want 1", o_fs); end
  endtask

  initial begin
    test_reset();
    test_timing();
    test_bars();
    test_external();
    test_mode_switch();
    test_patterns();
    test_reset_midline();
    test_en_drop();
    test_en_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
